// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS mult/div unit owning HI/LO, one bit per cycle with busy/done/stall handshake
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo, rem;
  logic div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, done_q, done_d;
  logic is_md, is_mv, sgn, ge;
  logic [WIDTH:0] msum, dtmp, ddiff;
  assign is_md = func[5:2] == 4'b0110;
  assign is_mv = func[5:2] == 4'b0100;
  assign sgn   = ~func[0];
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;
  // Multiply keeps the multiplier in acc low half; divide keeps {remainder, quotient} there.
  assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? b_q : '0};
  assign dtmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ddiff = dtmp - {1'b0, b_q};
  assign ge    = dtmp >= {1'b0, b_q};
  assign prod  = qneg_q ? -acc_q : acc_q;
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (op_valid && is_md) ? RUN : IDLE;
      RUN:     state_d = (cnt_q == '0) ? FIX : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (op_valid && is_md) begin
        cnt_d  = CW'(WIDTH - 1);
        acc_d  = {{WIDTH{1'b0}}, abs_a};
        a_d    = a;
        b_d    = abs_b;
        div_d  = func[1];
        qneg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d = sgn && a[WIDTH-1];
        zero_d = b == '0;
      end else if (op_valid && func == 6'b010001) begin
        hi_d = a;
      end else if (op_valid && func == 6'b010011) begin
        lo_d = a;
      end
    end else if (state_q == RUN) begin
      acc_d = div_q ? {ge ? ddiff[WIDTH-1:0] : dtmp[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                    : {msum, acc_q[WIDTH-1:1]};
      cnt_d = cnt_q - 1'b1;
    end else begin
      done_d = 1'b1;
      if (!div_q) begin
        {hi_d, lo_d} = prod;
      end else begin
        hi_d = zero_q ? a_q : (rneg_q ? -rem : rem);
        lo_d = zero_q ? '1  : (qneg_q ? -quo : quo);
      end
    end
  end
  always_comb begin
    busy      = state_q != IDLE;
    done      = done_q;
    stall     = op_valid && busy && (is_md || is_mv);
    hi        = hi_q;
    lo        = lo_q;
    mf_result = (func == 6'b010000) ? hi_q : (func == 6'b010010) ? lo_q : '0;
  end
endmodule
